// File: rtl/regfile_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, multi-cycle results wait in a 2-entry FIFO.
// Define REGFILE_SCAN_EN to build in the debug register-dump scan FSM; otherwise scan outputs are tied to 0.
module regfile_port_arbiter #(
  parameter int STALL_AGE = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        mu_valid,
  input  logic [4:0]  mu_addr,
  input  logic [31:0] mu_data,
  output logic        mu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
  output logic [31:0] busy_mask,
  output logic        stall_req,
  input  logic        scan_start,
  output logic [4:0]  scan_sel,
  input  logic [31:0] scan_data,
  output logic [31:0] scan_out,
  output logic        scan_valid,
  output logic        scan_done
);

  localparam logic [3:0] AGE_LIMIT = (STALL_AGE > 15) ? 4'd15 : 4'(STALL_AGE);

  logic [4:0]  ent_addr [2];
  logic [31:0] ent_data [2];
  logic [1:0]  ent_live;
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic [3:0]  age;

  logic wb_grant;
  logic fifo_nonempty;
  logic head_live;
  logic fifo_grant;
  logic pop;
  logic push;

  // A dead head (killed by a newer writeback) leaves the FIFO without using the write port.
  always_comb begin
    wb_grant      = wb_we && (wb_addr != 5'd0);
    fifo_nonempty = (count != 2'd0);
    head_live     = ent_live[rd_ptr];
    fifo_grant    = !wb_grant && fifo_nonempty && head_live;
    pop           = fifo_nonempty && (fifo_grant || !head_live);
    mu_ready      = (count < 2'd2) && !reset;
    push          = mu_valid && mu_ready && (mu_addr != 5'd0);
  end

  always_comb begin
    busy_mask = 32'd0;
    for (int i = 0; i < 2; i++) begin
      if (ent_live[i]) begin
        busy_mask = busy_mask | (32'd1 << ent_addr[i]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ent_live <= 2'b00;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wb_grant && ent_live[i] && (ent_addr[i] == wb_addr)) begin
          ent_live[i] <= 1'b0;
        end
      end
      if (pop) begin
        ent_live[rd_ptr] <= 1'b0;
        rd_ptr           <= ~rd_ptr;
      end
      // A same-cycle push is newer than the writeback, so it is never killed here.
      if (push) begin
        ent_addr[wr_ptr] <= mu_addr;
        ent_data[wr_ptr] <= mu_data;
        ent_live[wr_ptr] <= 1'b1;
        wr_ptr           <= ~wr_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rf_we   <= 1'b0;
      rf_addr <= 5'd0;
      rf_data <= 32'd0;
    end else if (wb_grant) begin
      rf_we   <= 1'b1;
      rf_addr <= wb_addr;
      rf_data <= wb_data;
    end else if (fifo_grant) begin
      rf_we   <= 1'b1;
      rf_addr <= ent_addr[rd_ptr];
      rf_data <= ent_data[rd_ptr];
    end else begin
      rf_we   <= 1'b0;
    end
  end

  // Age of a live head that keeps losing to writebacks; stall_req lags it by one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      age       <= 4'd0;
      stall_req <= 1'b0;
    end else if (pop) begin
      age       <= 4'd0;
      stall_req <= 1'b0;
    end else begin
      if (fifo_nonempty && head_live && !fifo_grant && (age != 4'hF)) begin
        age <= age + 4'd1;
      end
      stall_req <= (age >= AGE_LIMIT);
    end
  end

`ifdef REGFILE_SCAN_EN
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } scan_state_t;

  scan_state_t scan_state;
  scan_state_t scan_state_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      scan_state <= IDLE;
      scan_sel   <= 5'd0;
      scan_out   <= 32'd0;
      scan_valid <= 1'b0;
    end else begin
      scan_state <= scan_state_next;
      scan_valid <= (scan_state == RUN);
      if (scan_state == RUN) begin
        scan_out <= scan_data;
        scan_sel <= scan_sel + 5'd1;
      end else if (scan_state == IDLE) begin
        scan_sel <= 5'd0;
      end
    end
  end

  always_comb begin
    scan_state_next = scan_state;
    scan_done       = 1'b0;
    case (scan_state)
      IDLE: if (scan_start) scan_state_next = RUN;
      RUN:  if (scan_sel == 5'd31) scan_state_next = DONE;
      DONE: begin
        scan_done       = 1'b1;
        scan_state_next = IDLE;
      end
      default: scan_state_next = IDLE;
    endcase
  end
`else
  logic unused_scan;

  assign unused_scan = ^{scan_start, scan_data};
  assign scan_sel    = 5'd0;
  assign scan_out    = 32'd0;
  assign scan_valid  = 1'b0;
  assign scan_done   = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Scoreboard bench for regfile_port_arbiter: expected rf writes are queued as stimulus is driven.
// Scan checks follow REGFILE_SCAN_EN, matching however the RTL is built.
module tb_regfile_port_arbiter;

  localparam int STALL_AGE = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        mu_valid;
  logic [4:0]  mu_addr;
  logic [31:0] mu_data;
  logic        mu_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] busy_mask;
  logic        stall_req;
  logic        scan_start;
  logic [4:0]  scan_sel;
  logic [31:0] scan_data;
  logic [31:0] scan_out;
  logic        scan_valid;
  logic        scan_done;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fails  = 0;

  always #5 clock = ~clock;

  assign scan_data = {27'd0, scan_sel};

  regfile_port_arbiter #(.STALL_AGE(STALL_AGE)) dut (
    .clock(clock), .reset(reset),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .mu_valid(mu_valid), .mu_addr(mu_addr), .mu_data(mu_data), .mu_ready(mu_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .busy_mask(busy_mask), .stall_req(stall_req),
    .scan_start(scan_start), .scan_sel(scan_sel), .scan_data(scan_data),
    .scan_out(scan_out), .scan_valid(scan_valid), .scan_done(scan_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expectWrite(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic mv, input logic [4:0] ma, input logic [31:0] md);
    wb_we    = we;
    wb_addr  = wa;
    wb_data  = wd;
    mu_valid = mv;
    mu_addr  = ma;
    mu_data  = md;
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  // Every register-file write is matched in order against the scoreboard.
  always begin
    wr_t e;
    @(posedge clock);
    #1;
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_extra_write", {31'd0, rf_we}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sb_rf_addr", {27'd0, rf_addr}, {27'd0, e.addr});
        checkOutput("sb_rf_data", rf_data, e.data);
      end
    end
  end

  initial begin
    reset      = 1'b1;
    scan_start = 1'b0;
    wb_we      = 1'b0;
    wb_addr    = 5'd0;
    wb_data    = 32'd0;
    mu_valid   = 1'b0;
    mu_addr    = 5'd0;
    mu_data    = 32'd0;
    tick();
    tick();
    checkOutput("rst_rf_we", {31'd0, rf_we}, 32'd0);
    checkOutput("rst_rf_addr", {27'd0, rf_addr}, 32'd0);
    checkOutput("rst_rf_data", rf_data, 32'd0);
    checkOutput("rst_busy", busy_mask, 32'd0);
    checkOutput("rst_stall", {31'd0, stall_req}, 32'd0);
    checkOutput("rst_mu_ready", {31'd0, mu_ready}, 32'd0);
    checkOutput("rst_scan_valid", {31'd0, scan_valid}, 32'd0);
    checkOutput("rst_scan_out", scan_out, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("mu_ready_after_rst", {31'd0, mu_ready}, 32'd1);

    // Direct writeback, then an idle cycle holding the last address/data.
    expectWrite(5'd8, 32'h11);
    applyStimulus(1'b1, 5'd8, 32'h11, 1'b0, 5'd0, 32'd0);
    checkOutput("wb_rf_we", {31'd0, rf_we}, 32'd1);
    checkOutput("wb_rf_addr", {27'd0, rf_addr}, 32'd8);
    checkOutput("wb_rf_data", rf_data, 32'h11);
    idle(1);
    checkOutput("hold_rf_we", {31'd0, rf_we}, 32'd0);
    checkOutput("hold_rf_addr", {27'd0, rf_addr}, 32'd8);
    checkOutput("hold_rf_data", rf_data, 32'h11);

    // Writeback to register 0 is not a grant.
    applyStimulus(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
    checkOutput("wb_r0_rf_we", {31'd0, rf_we}, 32'd0);

    // Single mu result with the pipeline idle.
    expectWrite(5'd9, 32'h22);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h22);
    checkOutput("mu_busy_set", busy_mask, 32'h0000_0200);
    idle(1);
    checkOutput("mu_rf_addr", {27'd0, rf_addr}, 32'd9);
    checkOutput("mu_busy_clear", busy_mask, 32'd0);

    // mu result to register 0 completes without buffering.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
    checkOutput("mu_r0_busy", busy_mask, 32'd0);
    checkOutput("mu_r0_ready", {31'd0, mu_ready}, 32'd1);
    idle(1);
    checkOutput("mu_r0_rf_we", {31'd0, rf_we}, 32'd0);

    // Two buffered results starved by a busy pipeline, then drained in order.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] bm;
      expectWrite(5'(i + 1), 32'h100 + 32'(i));
      applyStimulus(1'b1, 5'(i + 1), 32'h100 + 32'(i), (i < 2), (i == 0) ? 5'd12 : 5'd13,
                    (i == 0) ? 32'hA0 : 32'hB0);
      bm = 32'h1000 | ((i >= 1) ? 32'h2000 : 32'd0);
      checkOutput($sformatf("starve_busy_%0d", i), busy_mask, bm);
      checkOutput($sformatf("starve_ready_%0d", i), {31'd0, mu_ready}, {31'd0, (i == 0)});
      checkOutput($sformatf("starve_stall_%0d", i), {31'd0, stall_req}, {31'd0, (i - 1 >= STALL_AGE)});
    end
    expectWrite(5'd12, 32'hA0);
    expectWrite(5'd13, 32'hB0);
    idle(1);
    checkOutput("drain_first_addr", {27'd0, rf_addr}, 32'd12);
    checkOutput("drain_stall_clear", {31'd0, stall_req}, 32'd0);
    idle(1);
    checkOutput("drain_busy_clear", busy_mask, 32'd0);
    idle(1);

    // A newer writeback kills a buffered entry to the same register.
    expectWrite(5'd5, 32'h50);
    applyStimulus(1'b1, 5'd5, 32'h50, 1'b1, 5'd10, 32'h44);
    checkOutput("kill_busy_set", busy_mask, 32'h0000_0400);
    expectWrite(5'd10, 32'h33);
    applyStimulus(1'b1, 5'd10, 32'h33, 1'b0, 5'd0, 32'd0);
    checkOutput("kill_busy_clear", busy_mask, 32'd0);
    idle(1);
    checkOutput("kill_pop_rf_we", {31'd0, rf_we}, 32'd0);
    checkOutput("kill_hold_data", rf_data, 32'h33);
    checkOutput("kill_pop_ready", {31'd0, mu_ready}, 32'd1);

    // Same-cycle push is newer than a matching writeback; then push and pop together.
    expectWrite(5'd11, 32'h66);
    expectWrite(5'd11, 32'h77);
    applyStimulus(1'b1, 5'd11, 32'h66, 1'b1, 5'd11, 32'h77);
    checkOutput("newer_busy", busy_mask, 32'h0000_0800);
    expectWrite(5'd14, 32'h88);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'h88);
    checkOutput("pushpop_busy", busy_mask, 32'h0000_4000);
    idle(1);
    checkOutput("pushpop_rf_data", rf_data, 32'h88);
    idle(2);

`ifdef REGFILE_SCAN_EN
    begin
      int idx;
      int dones;
      idx   = 0;
      dones = 0;
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      for (int c = 0; c < 40; c++) begin
        scan_start = (c == 10);
        tick();
        if (scan_valid === 1'b1) begin
          checkOutput($sformatf("scan_out_%0d", idx), scan_out, 32'(idx));
          idx++;
        end
        if (scan_done === 1'b1) dones++;
      end
      scan_start = 1'b0;
      checkOutput("scan_valid_count", 32'(idx), 32'd32);
      checkOutput("scan_done_count", 32'(dones), 32'd1);

      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("scan_rst_valid", {31'd0, scan_valid}, 32'd0);
      checkOutput("scan_rst_out", scan_out, 32'd0);
      checkOutput("scan_rst_sel", {27'd0, scan_sel}, 32'd0);
      checkOutput("scan_rst_done", {31'd0, scan_done}, 32'd0);
      tick();
      tick();
      checkOutput("scan_rst_idle_valid", {31'd0, scan_valid}, 32'd0);
    end
`else
    scan_start = 1'b1;
    tick();
    tick();
    checkOutput("scan_tied_valid", {31'd0, scan_valid}, 32'd0);
    checkOutput("scan_tied_out", scan_out, 32'd0);
    checkOutput("scan_tied_sel", {27'd0, scan_sel}, 32'd0);
    checkOutput("scan_tied_done", {31'd0, scan_done}, 32'd0);
    scan_start = 1'b0;
`endif

    idle(2);
    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/regfile_port_arbiter.md
REGFILE_PORT_ARBITER -- requirements
Module: regfile_port_arbiter

Interface
REQ-001 SHALL have parameter STALL_AGE, default 4, meaning the cycle count a buffered entry waits at FIFO head before stall_req asserts.
REQ-002 SHALL have port clock  in  1  single system clock, all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports wb_we in 1, wb_addr in 5, wb_data in 32: pipeline writeback request, no backpressure.
REQ-005 SHALL have ports mu_valid in 1, mu_addr in 5, mu_data in 32, mu_ready out 1: multi-cycle unit result, valid/ready handshake.
REQ-006 SHALL have ports rf_we out 1, rf_addr out 5, rf_data out 32: registered register-file write port.
REQ-007 SHALL have port busy_mask  out  32  bit n set while a live buffered write to register n is pending.
REQ-008 SHALL have port stall_req  out  1  registered request to the pipeline to suppress wb_we.
REQ-009 SHALL have ports scan_start in 1, scan_sel out 5, scan_data in 32, scan_out out 32, scan_valid out 1, scan_done out 1: debug register dump.

Function
REQ-010 SHALL write one register per cycle; rf_* SHALL be registered, 1-cycle latency from grant.
REQ-011 SHALL grant wb when wb_we=1 and wb_addr!=0; otherwise SHALL grant the FIFO head if the FIFO is non-empty and the head is live.
REQ-012 SHALL drive rf_we=0 and hold rf_addr/rf_data at their last values in cycles with no grant.
REQ-013 SHALL buffer mu requests in a 2-entry FIFO; mu_ready = (count<2) and not reset, computed from current count only (no same-cycle pop credit).
REQ-014 SHALL complete a handshake for mu_addr=0 without pushing an entry.
REQ-015 SHALL kill (clear live bit) any buffered entry whose addr equals a granted wb_addr in the same cycle; a killed head SHALL pop without asserting rf_we.
REQ-016 SHALL not kill an entry pushed in the same cycle as a matching wb grant (mu treated as newer).
REQ-017 SHALL support simultaneous push and pop; count wraps 0..2, pointers modulo 2.
REQ-018 SHALL set busy_mask as the OR of one-hot decodes of live entries, updated combinationally from FIFO state.
REQ-019 SHALL count head age (saturating at 15) for each cycle a live head is not granted; age SHALL clear on pop.
REQ-020 SHALL assert stall_req the cycle after age reaches STALL_AGE and deassert it the cycle after the head pops.
REQ-021 Scan FSM SHALL have states IDLE, RUN, DONE; IDLE->RUN on scan_start, scan_sel=0.
REQ-022 In RUN SHALL increment scan_sel each cycle; next cycle scan_out=scan_data sampled at that scan_sel, scan_valid=1.
REQ-023 SHALL go RUN->DONE after scan_sel=31 is sampled; DONE asserts scan_done one cycle, then IDLE.
REQ-024 SHALL ignore scan_start outside IDLE.

Reset
REQ-025 On reset SHALL set rf_we=0, rf_addr=0, rf_data=0, FIFO empty, busy_mask=0, age=0, stall_req=0, mu_ready=0.
REQ-026 On reset SHALL set scan FSM IDLE, scan_sel=0, scan_out=0, scan_valid=0, scan_done=0, aborting any scan in progress.

Configuration
REQ-027 Macro REGFILE_SCAN_EN defined SHALL compile in the scan FSM per REQ-021..024.
REQ-028 Without REGFILE_SCAN_EN SHALL tie scan_sel=0, scan_out=0, scan_valid=0, scan_done=0 and ignore scan_start and scan_data.

Verification
REQ-029 wb_we=1, addr=8, data=0x11 -> next cycle rf_we=1, rf_addr=8, rf_data=0x11.
REQ-030 mu push addr=9 data=0x22 with wb idle -> busy_mask bit 9 set, rf write addr 9 data 0x22 two cycles after handshake, busy_mask=0.
REQ-031 Two mu pushes while wb busy -> mu_ready=0; wb held busy -> stall_req=1 after STALL_AGE=4 cycles; wb released -> both entries drain in order.
REQ-032 Buffered addr=10, then wb_we addr=10 data=0x33 -> single rf write of 0x33, killed entry pops with rf_we=0, busy_mask bit 10 clears.
REQ-033 REGFILE_SCAN_EN, scan_start pulse with scan_data=scan_sel -> 32 scan_valid pulses, scan_out 0..31, scan_done once; reset mid-scan -> IDLE, outputs 0.
REQ-034 mu_addr=0 handshake -> no push, busy_mask=0, no rf write.
